// File: rtl/serdes_link_if.sv
// serdes_link_if: control/status bundle of the link sequencer (master = pins/PHY side driving enable, pll_lock, rx_comma_det, rx_code_err; slave = sequencer driving pll_en, tx_train, rx_align_en, link_up, fault, state, retry_cnt)
interface serdes_link_if;
  logic enable;
  logic pll_lock;
  logic rx_comma_det;
  logic rx_code_err;
  logic pll_en;
  logic tx_train;
  logic rx_align_en;
  logic link_up;
  logic fault;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  modport master (
    output enable, pll_lock, rx_comma_det, rx_code_err,
    input  pll_en, tx_train, rx_align_en, link_up, fault, state, retry_cnt
  );
  modport slave (
    input  enable, pll_lock, rx_comma_det, rx_code_err,
    output pll_en, tx_train, rx_align_en, link_up, fault, state, retry_cnt
  );
endinterface

// File: rtl/serdes_link_ctrl.sv
// serdes_link_ctrl: SerDes bring-up sequencer (PLL lock wait, comma training, error-rate monitor, retry/fault); ports clk, rst_n (async active-low), link (serdes_link_if.slave)
module serdes_link_ctrl #(
  parameter int LOCK_STABLE   = 8,
  parameter int PLL_TIMEOUT   = 256,
  parameter int ALIGN_TIMEOUT = 512,
  parameter int ALIGN_COMMAS  = 4,
  parameter int ERR_WINDOW    = 64,
  parameter int ERR_MAX       = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  serdes_link_if.slave link
);
  localparam int LW = $clog2(LOCK_STABLE);
  localparam int CW = $clog2(ALIGN_COMMAS);
  localparam int EW = $clog2(ERR_MAX);
  localparam int WW = $clog2(ERR_WINDOW);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] COMMA_LAST = CW'(ALIGN_COMMAS - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_MAX - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(ERR_WINDOW - 1);
  localparam logic [15:0]   PLL_LAST   = 16'(PLL_TIMEOUT - 1);
  localparam logic [15:0]   ALIGN_LAST = 16'(ALIGN_TIMEOUT - 1);
  localparam logic [1:0]    RETRY_LAST = 2'(MAX_RETRY);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLL_WAIT = 3'd1,
    TRAIN    = 3'd2,
    LINKED   = 3'd3,
    FAULT    = 3'd4
  } state_t;
  state_t st, nxt;
  logic [15:0] timer;
  logic [LW-1:0] lock_cnt;
  logic [CW-1:0] comma_cnt;
  logic [EW-1:0] err_cnt;
  logic [WW-1:0] win_cnt;
  logic [1:0] retry, retry_nxt;
  logic fail, fail_pll, linked_ok, clr, wrap, burst, comma_done;
  assign wrap       = win_cnt == WIN_LAST;
  assign burst      = link.rx_code_err && !wrap && err_cnt == ERR_LAST;
  assign comma_done = link.rx_comma_det && !link.rx_code_err && comma_cnt == COMMA_LAST;
  always_comb begin
    nxt       = st;
    fail      = 1'b0;
    fail_pll  = 1'b0;
    linked_ok = 1'b0;
    if (!link.enable) nxt = IDLE;
    else
      case (st)
        IDLE:     nxt = PLL_WAIT;
        PLL_WAIT:
          if (link.pll_lock && lock_cnt == LOCK_LAST) nxt = TRAIN;
          else if (timer == PLL_LAST) {fail, fail_pll} = 2'b11;
        TRAIN:
          if (!link.pll_lock) {fail, fail_pll} = 2'b11;
          else if (comma_done) begin
            nxt       = LINKED;
            linked_ok = 1'b1;
          end
          else if (timer == ALIGN_LAST) fail = 1'b1;
        LINKED:
          if (!link.pll_lock) {fail, fail_pll} = 2'b11;
          else if (burst) fail = 1'b1;
        FAULT:    nxt = FAULT;
        default:  nxt = IDLE;
      endcase
    if (fail) nxt = retry == RETRY_LAST ? FAULT : fail_pll ? PLL_WAIT : TRAIN;
    // a failure that re-enters the current state still restarts its counters
    clr       = !link.enable || fail || nxt != st;
    retry_nxt = (!link.enable || linked_ok) ? 2'd0 : (fail && retry != RETRY_LAST) ? retry + 2'd1 : retry;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      retry     <= '0;
      timer     <= '0;
      lock_cnt  <= '0;
      comma_cnt <= '0;
      err_cnt   <= '0;
      win_cnt   <= '0;
    end else begin
      retry     <= retry_nxt;
      timer     <= clr ? '0 : timer + {15'd0, ~&timer};
      lock_cnt  <= (clr || st != PLL_WAIT || !link.pll_lock) ? '0 : lock_cnt + LW'(1);
      comma_cnt <= (clr || st != TRAIN || link.rx_code_err) ? '0 : comma_cnt + CW'(link.rx_comma_det);
      // an error on the wrap cycle is the first of the new window
      err_cnt   <= (clr || st != LINKED) ? '0 : wrap ? EW'(link.rx_code_err) : err_cnt + EW'(link.rx_code_err);
      win_cnt   <= (clr || st != LINKED || wrap) ? '0 : win_cnt + WW'(1);
    end
  assign link.pll_en      = st inside {PLL_WAIT, TRAIN, LINKED};
  assign link.tx_train    = st == TRAIN;
  assign link.rx_align_en = st == TRAIN;
  assign link.link_up     = st == LINKED;
  assign link.fault       = st == FAULT;
  assign link.state       = st;
  assign link.retry_cnt   = retry;
endmodule
